// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer.
// A shared divider produces a sample strobe from clk_100MHz. Each channel
// synchronizes its raw pin and accepts a new level only after STABLE_CNT
// consecutive disagreeing samples, emitting a one-cycle press/release pulse
// on the edge that changes the level.

module button_debouncer_lane #(
  parameter int STABLE_CNT = 4
) (
  input  logic clk_100MHz,
  input  logic clr,
  input  logic sample_tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);
  localparam int CW = $clog2(STABLE_CNT + 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer; only sync2 feeds the decision logic.
  always_ff @(posedge clk_100MHz) begin
    if (clr) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Count disagreeing samples; any agreeing sample restarts the count.
  // Pulses are cleared every cycle and set only on the accepting edge.
  always_ff @(posedge clk_100MHz) begin
    if (clr) begin
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      if (sample_tick) begin
        if (sync2 == btn_level) begin
          cnt <= '0;
        end else if (cnt == CW'(STABLE_CNT - 1)) begin
          cnt         <= '0;
          btn_level   <= sync2;
          btn_press   <= sync2;
          btn_release <= ~sync2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

module button_debouncer #(
  parameter int N_BTN      = 5,
  parameter int TICK_DIV   = 524288,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk_100MHz,
  input  logic             clr,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             sample_tick
);
  localparam int TW = $clog2(TICK_DIV);

  logic [TW-1:0] tick_cnt;

  // Free-running 0..TICK_DIV-1 divider; the strobe marks its last count.
  always_ff @(posedge clk_100MHz) begin
    if (clr)                                tick_cnt <= '0;
    else if (tick_cnt == TW'(TICK_DIV - 1)) tick_cnt <= '0;
    else                                    tick_cnt <= tick_cnt + TW'(1);
  end

  assign sample_tick = (tick_cnt == TW'(TICK_DIV - 1));

  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    button_debouncer_lane #(
      .STABLE_CNT (STABLE_CNT)
    ) u_lane (
      .clk_100MHz  (clk_100MHz),
      .clr         (clr),
      .sample_tick (sample_tick),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end
endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with TICK_DIV=4, STABLE_CNT=3, N_BTN=5.
// Cycle numbering: cyc==1 is the first cycle after clr deasserts; ticks
// land on cycles 4, 8, 12, ... A raw change driven in cycle c is seen by
// sync2 in cycle c+2; an accepting tick in cycle t shows its pulse in t+1.

module tb_button_debouncer;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         clr;
  logic [N-1:0] btn_raw;
  logic [N-1:0] level, press, rel;
  logic         tick;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int           cyc;
    logic [N-1:0] pr;
    logic [N-1:0] rl;
    logic [N-1:0] lv;
  } ev_t;

  ev_t q[$];

  button_debouncer #(
    .N_BTN      (N),
    .TICK_DIV   (4),
    .STABLE_CNT (3)
  ) dut (
    .clk_100MHz  (clk),
    .clr         (clr),
    .btn_raw     (btn_raw),
    .btn_level   (level),
    .btn_press   (press),
    .btn_release (rel),
    .sample_tick (tick)
  );

  always #5 clk = ~clk;

  // Cycle index relative to the most recent clr.
  always @(posedge clk) cyc <= clr ? 1 : cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cyc=%0d: got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [N-1:0] pr, input logic [N-1:0] rl,
                      input logic [N-1:0] lv);
    ev_t e;
    e.cyc = c; e.pr = pr; e.rl = rl; e.lv = lv;
    q.push_back(e);
  endtask

  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: tick cadence every cycle, and every pulse is matched
  // against the next expected event.
  always @(negedge clk) begin
    ev_t e;
    chk("sample_tick", 32'(tick), 32'(cyc % 4 == 0));
    if ((|press) || (|rel)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse at cyc=%0d: press=%b release=%b expected none",
                 cyc, press, rel);
      end else begin
        e = q.pop_front();
        chk("event_cycle", 32'(cyc), 32'(e.cyc));
        chk("event_press", 32'(press), 32'(e.pr));
        chk("event_release", 32'(rel), 32'(e.rl));
        chk("event_level", 32'(level), 32'(e.lv));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    clr     = 1'b1;
    btn_raw = '1;
    repeat (2) begin
      @(negedge clk);
      chk("reset_outputs", 32'({level, press, rel, tick}), 32'd0);
    end
    @(posedge clk); #1;
    clr     = 1'b0;
    btn_raw = '0;

    // Clean press on bit0, independent presses on bit3/bit4, bit0 release
    // coinciding with the bit4 press.
    go(2);  btn_raw[0] = 1'b1; push(13, 5'b00001, 5'b00000, 5'b01001 & 5'b00001);
    go(10); btn_raw[3] = 1'b1; push(21, 5'b01000, 5'b00000, 5'b01001);
    go(14); btn_raw[0] = 1'b0; btn_raw[4] = 1'b1;
            push(25, 5'b10000, 5'b00001, 5'b11000);

    // Bounce on bit1: ticks 28..44 see 1,0,1,1,1.
    go(26); btn_raw[1] = 1'b1; push(45, 5'b00010, 5'b00000, 5'b11010);
    go(29); btn_raw[1] = 1'b0;
    go(31); btn_raw[1] = 1'b1;
    go(46); chk("level_after_bounce", 32'(level), 32'(5'b11010));

    // Glitch on bit2: sync2 high only in cycles 49,50, between ticks 48/52.
    go(47); btn_raw[2] = 1'b1;
    go(49); btn_raw[2] = 1'b0;
    go(53); chk("level_after_glitch", 32'(level), 32'(5'b11010));

    // bit0 pressed; ticks 56 and 60 count it, then clr discards the count.
    go(54); btn_raw[0] = 1'b1;
    go(61); clr = 1'b1;
            push(13, 5'b11011, 5'b00000, 5'b11011);
    @(posedge clk); #1;
    clr = 1'b0;
    chk("outputs_after_midclr", 32'({level, press, rel}), 32'd0);
    go(12); chk("level_before_reaccept", 32'(level), 32'd0);

    // Release all held buttons together.
    go(14); btn_raw = '0; push(25, 5'b00000, 5'b11011, 5'b00000);
    go(30);
    chk("final_level", 32'(level), 32'd0);
    chk("pending_events", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
